// File: rtl/wb_queue_pkg.sv
// Shared widths and entry type for the write-back queue.
package wb_queue_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  // One pending write-back: destination register and value.
  typedef struct packed {
    logic [ADDR_W-1:0] dir;
    logic [DATA_W-1:0] dato;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Address compare and youngest-select for one register-bank read port.
// With WBQ_BYPASS_EN defined, the matching value is also selected onto fwd.
module wbq_match
  import wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic [ADDR_W-1:0]             dl,
  input  logic [PTR_W-1:0]              head,
  input  logic [CNT_W-1:0]              count,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  dirs,
  input  logic                          out_we,
  input  logic [ADDR_W-1:0]             out_dir,
`ifdef WBQ_BYPASS_EN
  input  logic [DEPTH-1:0][DATA_W-1:0]  datos,
  input  logic [DATA_W-1:0]             out_dato,
  output logic [DATA_W-1:0]             fwd,
`endif
  output logic                          pend
);

  logic [PTR_W-1:0] slot;

  // Walk from oldest to youngest so the last hit wins; output register is oldest of all.
  always_comb begin
    pend = 1'b0;
    slot = '0;
`ifdef WBQ_BYPASS_EN
    fwd  = '0;
`endif
    if (out_we && (out_dir == dl)) begin
      pend = 1'b1;
`ifdef WBQ_BYPASS_EN
      fwd  = out_dato;
`endif
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = PTR_W'(head + PTR_W'(i));
      if ((CNT_W'(i) < count) && (dirs[slot] == dl)) begin
        pend = 1'b1;
`ifdef WBQ_BYPASS_EN
        fwd  = datos[slot];
`endif
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers results in front of the register bank write port
// and flags read addresses that still have an uncommitted write.
// Optional macro WBQ_BYPASS_EN adds fwd1/fwd2 youngest-value forwarding.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_dir,
  input  logic [DATA_W-1:0] in_dato,
  output logic              in_ready,
  input  logic              drain_en,
  output logic [ADDR_W-1:0] Dir,
  output logic [DATA_W-1:0] Dato,
  output logic              WE,
  input  logic [ADDR_W-1:0] DL1,
  input  logic [ADDR_W-1:0] DL2,
  output logic              pend1,
  output logic              pend2,
`ifdef WBQ_BYPASS_EN
  output logic [DATA_W-1:0] fwd1,
  output logic [DATA_W-1:0] fwd2,
`endif
  output logic [CNT_W-1:0]  count
);

  wbq_entry_t mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic push;
  logic pop;
  logic [DEPTH-1:0][ADDR_W-1:0] dirs;
`ifdef WBQ_BYPASS_EN
  logic [DEPTH-1:0][DATA_W-1:0] datos;
`endif

  // Handshake: full blocks pushes even when a pop frees a slot the same cycle.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && drain_en;

  // Flatten storage for the match units.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      dirs[i]  = mem[i].dir;
`ifdef WBQ_BYPASS_EN
      datos[i] = mem[i].dato;
`endif
    end
  end

  // Entry storage; validity is tracked by head/count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{dir: in_dir, dato: in_dato};
    end
  end

  // Pointers, occupancy and registered bank write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      WE    <= 1'b0;
      Dir   <= '0;
      Dato  <= '0;
    end else begin
      WE <= pop;
      if (pop) begin
        Dir  <= mem[head].dir;
        Dato <= mem[head].dato;
        head <= PTR_W'(head + 1'b1);
      end
      if (push) begin
        tail <= PTR_W'(tail + 1'b1);
      end
      unique case ({push, pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  wbq_match #(.DEPTH(DEPTH)) u_match1 (
    .dl       (DL1),
    .head     (head),
    .count    (count),
    .dirs     (dirs),
    .out_we   (WE),
    .out_dir  (Dir),
`ifdef WBQ_BYPASS_EN
    .datos    (datos),
    .out_dato (Dato),
    .fwd      (fwd1),
`endif
    .pend     (pend1)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match2 (
    .dl       (DL2),
    .head     (head),
    .count    (count),
    .dirs     (dirs),
    .out_we   (WE),
    .out_dir  (Dir),
`ifdef WBQ_BYPASS_EN
    .datos    (datos),
    .out_dato (Dato),
    .fwd      (fwd2),
`endif
    .pend     (pend2)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Randomized self-checking bench for wb_queue against a queue-based model.
module tb_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [4:0]       in_dir = '0;
  logic [31:0]      in_dato = '0;
  logic             in_ready;
  logic             drain_en = 1'b0;
  logic [4:0]       dir_o;
  logic [31:0]      dato_o;
  logic             we_o;
  logic [4:0]       dl1 = '0;
  logic [4:0]       dl2 = '0;
  logic             pend1;
  logic             pend2;
`ifdef WBQ_BYPASS_EN
  logic [31:0]      fwd1;
  logic [31:0]      fwd2;
`endif
  logic [CNT_W-1:0] count;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_dir   (in_dir),
    .in_dato  (in_dato),
    .in_ready (in_ready),
    .drain_en (drain_en),
    .Dir      (dir_o),
    .Dato     (dato_o),
    .WE       (we_o),
    .DL1      (dl1),
    .DL2      (dl2),
    .pend1    (pend1),
    .pend2    (pend2),
`ifdef WBQ_BYPASS_EN
    .fwd1     (fwd1),
    .fwd2     (fwd2),
`endif
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dir;
    logic [31:0] dato;
  } ent_t;

  ent_t        mq[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_dir  = '0;
  logic [31:0] m_dato = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  // Youngest pending write to address a: newest queue entry first, then the output register.
  function automatic void lookup(input logic [4:0] a, output logic p, output logic [31:0] v);
    p = 1'b0;
    v = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].dir == a) begin
        p = 1'b1;
        v = mq[i].dato;
        return;
      end
    end
    if (m_we && (m_dir == a)) begin
      p = 1'b1;
      v = m_dato;
    end
  endfunction

  // One clock: drive, check combinational outputs, clock, update model, check registers.
  task automatic cycle(input logic v, input logic [4:0] d, input logic [31:0] x,
                       input logic de, input logic r);
    logic        p;
    logic [31:0] fv;
    bit          do_push;
    bit          do_pop;
    ent_t        e;
    in_valid = v;
    in_dir   = d;
    in_dato  = x;
    drain_en = de;
    rst      = r;
    #2;
    if (!r) begin
      check("in_ready", 32'(in_ready), 32'(mq.size() < int'(DEPTH)));
      lookup(dl1, p, fv);
      check("pend1", 32'(pend1), 32'(p));
`ifdef WBQ_BYPASS_EN
      check("fwd1", fwd1, fv);
`endif
      lookup(dl2, p, fv);
      check("pend2", 32'(pend2), 32'(p));
`ifdef WBQ_BYPASS_EN
      check("fwd2", fwd2, fv);
`endif
    end
    do_pop  = (mq.size() > 0) && de;
    do_push = v && (mq.size() < int'(DEPTH));
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_we   = 1'b0;
      m_dir  = '0;
      m_dato = '0;
    end else begin
      m_we = do_pop;
      if (do_pop) begin
        e      = mq.pop_front();
        m_dir  = e.dir;
        m_dato = e.dato;
      end
      if (do_push) begin
        e.dir  = d;
        e.dato = x;
        mq.push_back(e);
      end
    end
    #1;
    check("WE", 32'(we_o), 32'(m_we));
    check("Dir", 32'(dir_o), 32'(m_dir));
    check("Dato", dato_o, m_dato);
    check("count", 32'(count), 32'(mq.size()));
  endtask

  initial begin
    // Reset
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single push with drain: WE two cycles after push, one cycle wide
    dl1 = 5'd5;
    cycle(1'b1, 5'd5, 32'h0000_00AA, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    check("lat_dir", 32'(dir_o), 32'd5);
    check("lat_dato", dato_o, 32'h0000_00AA);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    check("lat_we_low", 32'(we_o), 32'd0);

    // Fill to DEPTH, extra push ignored, then drain in order (address 0 included)
    for (int i = 0; i < int'(DEPTH) + 1; i++)
      cycle(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < int'(DEPTH) + 1; i++)
      cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Two writes to r3: youngest wins, clears after both drain
    dl1 = 5'd3;
    dl2 = 5'd0;
    cycle(1'b1, 5'd3, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 5'd3, 32'h22, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("r3_pend", 32'(pend1), 32'd1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    check("r3_clear", 32'(pend1), 32'd0);

    // Full queue with push and pop together: pop only
    for (int i = 0; i < int'(DEPTH); i++)
      cycle(1'b1, 5'(i + 8), 32'h200 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 5'd30, 32'hDEAD, 1'b1, 1'b0);
    check("fullpp_count", 32'(count), 32'(DEPTH - 1));

    // Reset discards queued entries
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'(i + 1), 32'h300 + 32'(i), 1'b0, 1'b0);
    dl1 = 5'd1;
    dl2 = 5'd2;
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Steady push/pop pairs across pointer wrap
    cycle(1'b1, 5'd7, 32'h400, 1'b0, 1'b0);
    for (int i = 0; i < 2 * int'(DEPTH) + 1; i++)
      cycle(1'b1, 5'(i), 32'h500 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Random traffic with varying drain pressure
    for (int i = 0; i < 600; i++) begin
      dl1 = 5'($urandom_range(0, 7));
      dl2 = 5'($urandom_range(0, 7));
      cycle(1'b1 && ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)),
            $urandom,
            ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
